stim_gen: RTL and testbench
===========================

Name: stim_gen

Overview:
Stimulus source for the arithmetic testbench; drives operand pairs into the DUT and, in parallel, into the monitor's i_dut_ia/i_dut_ib.
- Emits one operand pair per clk while running, since the monitor samples every cycle.
- Three patterns: pseudo-random (LFSR), sweep, and a fixed corner-case table.
- Run length is programmable, with busy and done status and a vector count for the controller.

Parameters:
WIDTH, 32, operand width; only 32 is supported.
SEED_A, 32'h00000001, reset/start seed of operand-A LFSR; value 0 is replaced by 1.
SEED_B, 32'h0000ACE1, reset/start seed of operand-B LFSR; value 0 is replaced by 1.

Ports:
clk  input  1  single clock.
reset  input  1  asynchronous, active-high reset.
i_start  input  1  pulse; begins a run when the FSM is in IDLE or DONE.
i_stop  input  1  ends a run early.
i_mode  input  2  pattern select, latched at start: 00 LFSR, 01 sweep, 10 corner, 11 reserved (behaves as 00).
i_num_vec  input  32  vectors per run, latched at start; 0 means unbounded.
o_ia  output  WIDTH  operand A to DUT/monitor.
o_ib  output  WIDTH  operand B to DUT/monitor.
o_valid  output  1  high when o_ia/o_ib carry a new vector this cycle.
o_busy  output  1  high in RUN.
o_done  output  1  high in DONE, cleared by next start.
o_vec_cnt  output  32  vectors emitted in current/last run; saturates at 32'hFFFFFFFF.

Behaviour:
- FSM states: IDLE, RUN, DONE. Reset leads to IDLE.
- Reset values: o_ia=0, o_ib=0, o_valid=0, o_busy=0, o_done=0, o_vec_cnt=0. LFSRs load SEED_A/SEED_B; sweep index=0; corner pointer=0.
- IDLE/DONE on i_start:
  - latch mode and num_vec;
  - reload LFSR seeds, sweep index and corner pointer;
  - clear o_vec_cnt and o_done;
  - go to RUN.
- Latency: i_start high at edge N gives first vector with o_valid=1 after edge N+1. Vectors then follow back-to-back, one per cycle.
- RUN:
  - every cycle, outputs are registered with the next vector, o_valid=1, o_vec_cnt increments.
  - When o_vec_cnt reaches num_vec (num_vec≠0), the last vector's cycle is followed by DONE: o_valid=0, o_busy=0, o_done=1.
- i_stop in RUN: the next edge enters DONE with no further vector. i_stop wins over a simultaneous terminal count. i_stop outside RUN is ignored.
- i_start in RUN is ignored. i_start together with i_stop in IDLE/DONE: start wins.
- In IDLE/DONE, o_ia/o_ib hold their last values and o_valid=0.
- LFSR mode:
  - each operand uses a 32-bit Galois LFSR, taps 32'h80200003; next = (s>>1) ^ (s[0] ? 32'h80200003 : 0).
  - First vector of a run is the seed itself, then it advances once per vector.
- Sweep mode: o_ia = index, o_ib = ~index; index starts at 0, increments per vector and wraps 32'hFFFFFFFF→0.
- Corner mode: 8-entry table, pointer wraps 7→0:
  - (0,0), (0,1), (1,0), (FFFFFFFF,1)
  - (7FFFFFFF,1), (80000000,80000000), (FFFFFFFF,FFFFFFFF), (AAAAAAAA,55555555)
- o_vec_cnt saturates in unbounded runs and never wraps.
- Reset asserted mid-run returns immediately to reset values, independent of clk.

Optional Feature:
STIM_GEN_RESEED_EN
- Defined: adds ports i_seed_load (1) and i_seed_a, i_seed_b (WIDTH each).
  - i_seed_load high in IDLE/DONE writes the seed registers; 0 is stored as 1.
  - Subsequent starts reload these seeds. Reset restores parameter seeds.
  - i_seed_load in RUN is ignored.
- Undefined: ports absent; seeds are always SEED_A/SEED_B.

Test Plan:
- Reset, then start with mode=00, num_vec=3 → o_ia = 00000001, 80200003, C0300002 on 3 consecutive o_valid cycles; next cycle o_done=1, o_busy=0, o_vec_cnt=3.
- mode=01, num_vec=4 → (0,FFFFFFFF), (1,FFFFFFFE), (2,FFFFFFFD), (3,FFFFFFFC), then DONE.
- mode=10, num_vec=10 → 8 table entries in order, then (0,0), (0,1); o_vec_cnt=10.
- mode=00, num_vec=0, i_stop after 5 vectors → exactly 5 valid cycles, o_done=1; a second start replays from 00000001.
- Async reset pulsed mid-run between clock edges → all outputs 0 immediately; FSM in IDLE.
- With STIM_GEN_RESEED_EN: load seed_a=0 → first vector o_ia=00000001. Load seed_a=2 → o_ia = 00000002, 00000001, 80200003.

Source files
------------

// File: rtl/stim_gen.sv
// Operand-pair stimulus source: LFSR, sweep and corner-table patterns with run control.
// Optional STIM_GEN_RESEED_EN adds runtime-loadable LFSR seeds.
module stim_gen #(
    parameter int          WIDTH  = 32,
    parameter logic [31:0] SEED_A = 32'h00000001,
    parameter logic [31:0] SEED_B = 32'h0000ACE1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_start,
    input  logic             i_stop,
    input  logic [1:0]       i_mode,
    input  logic [31:0]      i_num_vec,
`ifdef STIM_GEN_RESEED_EN
    input  logic             i_seed_load,
    input  logic [WIDTH-1:0] i_seed_a,
    input  logic [WIDTH-1:0] i_seed_b,
`endif
    output logic [WIDTH-1:0] o_ia,
    output logic [WIDTH-1:0] o_ib,
    output logic             o_valid,
    output logic             o_busy,
    output logic             o_done,
    output logic [31:0]      o_vec_cnt
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    localparam logic [WIDTH-1:0] TAPS    = WIDTH'(32'h80200003);
    localparam logic [WIDTH-1:0] SEED_A0 = (SEED_A == '0) ? WIDTH'(1) : WIDTH'(SEED_A);
    localparam logic [WIDTH-1:0] SEED_B0 = (SEED_B == '0) ? WIDTH'(1) : WIDTH'(SEED_B);

    state_t           r_state, w_state_nxt;
    logic [1:0]       r_mode;
    logic [31:0]      r_num_vec;
    logic [WIDTH-1:0] r_lfsr_a, r_lfsr_b;
    logic [WIDTH-1:0] r_sweep;
    logic [2:0]       r_cptr;
    logic [WIDTH-1:0] r_ia, r_ib;
    logic             r_valid;
    logic [31:0]      r_vec_cnt;
    logic [WIDTH-1:0] w_seed_a, w_seed_b;
    logic [WIDTH-1:0] w_va, w_vb;
    logic             w_load, w_emit, w_term;

`ifdef STIM_GEN_RESEED_EN
    logic [WIDTH-1:0] r_seed_a, r_seed_b;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seed_a <= SEED_A0;
            r_seed_b <= SEED_B0;
        end else if (i_seed_load && r_state != S_RUN) begin
            r_seed_a <= (i_seed_a == '0) ? WIDTH'(1) : i_seed_a;
            r_seed_b <= (i_seed_b == '0) ? WIDTH'(1) : i_seed_b;
        end
    end

    assign w_seed_a = r_seed_a;
    assign w_seed_b = r_seed_b;
`else
    assign w_seed_a = SEED_A0;
    assign w_seed_b = SEED_B0;
`endif

    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        return (s >> 1) ^ (s[0] ? TAPS : '0);
    endfunction

    // Terminal count is evaluated after the last vector is already on the outputs.
    assign w_term = (r_num_vec != '0) && (r_vec_cnt == r_num_vec);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_emit      = 1'b0;
        case (r_state)
            S_RUN: begin
                if (i_stop || w_term) w_state_nxt = S_DONE;
                else                  w_emit      = 1'b1;
            end
            default: begin
                if (i_start) begin
                    w_state_nxt = S_RUN;
                    w_load      = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        w_va = r_lfsr_a;
        w_vb = r_lfsr_b;
        case (r_mode)
            2'b01: begin
                w_va = r_sweep;
                w_vb = ~r_sweep;
            end
            2'b10: begin
                case (r_cptr)
                    3'd0:    begin w_va = 32'h00000000; w_vb = 32'h00000000; end
                    3'd1:    begin w_va = 32'h00000000; w_vb = 32'h00000001; end
                    3'd2:    begin w_va = 32'h00000001; w_vb = 32'h00000000; end
                    3'd3:    begin w_va = 32'hFFFFFFFF; w_vb = 32'h00000001; end
                    3'd4:    begin w_va = 32'h7FFFFFFF; w_vb = 32'h00000001; end
                    3'd5:    begin w_va = 32'h80000000; w_vb = 32'h80000000; end
                    3'd6:    begin w_va = 32'hFFFFFFFF; w_vb = 32'hFFFFFFFF; end
                    default: begin w_va = 32'hAAAAAAAA; w_vb = 32'h55555555; end
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mode    <= '0;
            r_num_vec <= '0;
            r_lfsr_a  <= SEED_A0;
            r_lfsr_b  <= SEED_B0;
            r_sweep   <= '0;
            r_cptr    <= '0;
            r_ia      <= '0;
            r_ib      <= '0;
            r_valid   <= 1'b0;
            r_vec_cnt <= '0;
        end else if (w_load) begin
            r_mode    <= i_mode;
            r_num_vec <= i_num_vec;
            r_lfsr_a  <= w_seed_a;
            r_lfsr_b  <= w_seed_b;
            r_sweep   <= '0;
            r_cptr    <= '0;
            r_valid   <= 1'b0;
            r_vec_cnt <= '0;
        end else if (w_emit) begin
            r_ia    <= w_va;
            r_ib    <= w_vb;
            r_valid <= 1'b1;
            if (r_vec_cnt != '1) r_vec_cnt <= r_vec_cnt + 32'd1;
            case (r_mode)
                2'b01:   r_sweep <= r_sweep + WIDTH'(1);
                2'b10:   r_cptr  <= r_cptr + 3'd1;
                default: begin
                    r_lfsr_a <= lfsr_step(r_lfsr_a);
                    r_lfsr_b <= lfsr_step(r_lfsr_b);
                end
            endcase
        end else begin
            r_valid <= 1'b0;
        end
    end

    assign o_ia      = r_ia;
    assign o_ib      = r_ib;
    assign o_valid   = r_valid;
    assign o_busy    = (r_state == S_RUN);
    assign o_done    = (r_state == S_DONE);
    assign o_vec_cnt = r_vec_cnt;

endmodule

// File: tb/tb_stim_gen.sv
// Self-checking bench for stim_gen: per-vector model, cycle compare, literal pins.
// Build with STIM_GEN_RESEED_EN defined to exercise the seed-load ports as well.
module tb_stim_gen;

    localparam logic [31:0] SA = 32'h00000001;
    localparam logic [31:0] SB = 32'h0000ACE1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        i_start = 1'b0;
    logic        i_stop = 1'b0;
    logic [1:0]  i_mode = 2'b00;
    logic [31:0] i_num_vec = '0;
    logic [31:0] o_ia, o_ib, o_vec_cnt;
    logic        o_valid, o_busy, o_done;
`ifdef STIM_GEN_RESEED_EN
    logic        i_seed_load = 1'b0;
    logic [31:0] i_seed_a = '0;
    logic [31:0] i_seed_b = '0;
`endif

    stim_gen #(.WIDTH(32), .SEED_A(SA), .SEED_B(SB)) dut (
        .clk(clk), .reset(reset), .i_start(i_start), .i_stop(i_stop),
        .i_mode(i_mode), .i_num_vec(i_num_vec),
`ifdef STIM_GEN_RESEED_EN
        .i_seed_load(i_seed_load), .i_seed_a(i_seed_a), .i_seed_b(i_seed_b),
`endif
        .o_ia(o_ia), .o_ib(o_ib), .o_valid(o_valid), .o_busy(o_busy),
        .o_done(o_done), .o_vec_cnt(o_vec_cnt)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h @%0t", name, act, exp, $time);
        end
    endtask

    // Model: the k-th vector of a run is computed directly from the pattern rules.
    logic [31:0] ca [8] = '{32'h0, 32'h0, 32'h1, 32'hFFFFFFFF, 32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hAAAAAAAA};
    logic [31:0] cb [8] = '{32'h0, 32'h1, 32'h0, 32'h1, 32'h1, 32'h80000000, 32'hFFFFFFFF, 32'h55555555};

    function automatic logic [31:0] lstep(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h80200003 : 32'h0);
    endfunction

    function automatic void vec_k(input logic [1:0] mode, input int unsigned k,
                                  input logic [31:0] sa, input logic [31:0] sb,
                                  output logic [31:0] a, output logic [31:0] b);
        if (mode == 2'b01) begin
            a = k;
            b = ~a;
        end else if (mode == 2'b10) begin
            a = ca[k % 8];
            b = cb[k % 8];
        end else begin
            a = sa;
            b = sb;
            for (int unsigned i = 0; i < k; i++) begin
                a = lstep(a);
                b = lstep(b);
            end
        end
    endfunction

    int          m_st = 0;          // 0 idle, 1 run, 2 done
    logic [1:0]  m_mode = '0;
    logic [31:0] m_num = '0, m_cnt = '0, m_ia = '0, m_ib = '0;
    logic        m_valid = 1'b0;
    int unsigned m_k = 0;
    logic [31:0] m_seed_a = SA, m_seed_b = SB, m_run_a = SA, m_run_b = SB;
    logic [31:0] exp_a_q [$];
    logic [31:0] exp_b_q [$];

    always @(posedge clk or posedge reset) begin
        logic [31:0] a, b;
        if (reset) begin
            m_st = 0; m_ia = '0; m_ib = '0; m_valid = 1'b0; m_cnt = '0; m_k = 0;
            m_seed_a = SA; m_seed_b = SB;
        end else if (m_st == 1) begin
            if (i_stop || (m_num != 0 && m_cnt == m_num)) begin
                m_st = 2;
                m_valid = 1'b0;
            end else begin
                vec_k(m_mode, m_k, m_run_a, m_run_b, a, b);
                m_ia = a; m_ib = b; m_valid = 1'b1;
                m_k++;
                if (m_cnt != 32'hFFFFFFFF) m_cnt++;
                exp_a_q.push_back(a);
                exp_b_q.push_back(b);
            end
        end else begin
            m_valid = 1'b0;
            if (i_start) begin
                m_st = 1; m_mode = i_mode; m_num = i_num_vec; m_cnt = '0; m_k = 0;
                m_run_a = m_seed_a; m_run_b = m_seed_b;
            end
`ifdef STIM_GEN_RESEED_EN
            if (i_seed_load) begin
                m_seed_a = (i_seed_a == 0) ? 32'h1 : i_seed_a;
                m_seed_b = (i_seed_b == 0) ? 32'h1 : i_seed_b;
            end
`endif
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("valid", {31'b0, o_valid}, {31'b0, m_valid});
            chk("busy", {31'b0, o_busy}, {31'b0, m_st == 1});
            chk("done", {31'b0, o_done}, {31'b0, m_st == 2});
            chk("vec_cnt", o_vec_cnt, m_cnt);
            chk("ia", o_ia, m_ia);
            chk("ib", o_ib, m_ib);
        end
    end

    task automatic start_run(input logic [1:0] mode, input logic [31:0] num);
        exp_a_q.delete();
        exp_b_q.delete();
        i_start = 1'b1; i_mode = mode; i_num_vec = num;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget && !o_done; i++) @(negedge clk);
        chk("done_reached", {31'b0, o_done}, 32'h1);
    endtask

    task automatic wait_vecs(input int n, input int budget);
        for (int i = 0; i < budget && exp_a_q.size() < n; i++) @(negedge clk);
        chk("vec_wait", exp_a_q.size(), n);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_ia", o_ia, 32'h0);
        chk("rst_valid", {31'b0, o_valid}, 32'h0);
        chk("rst_cnt", o_vec_cnt, 32'h0);

        i_stop = 1'b1;              // stop while idle must do nothing
        @(negedge clk);
        i_stop = 1'b0;

        start_run(2'b00, 32'd3);
        wait_done(20);
        chk("lfsr_n", exp_a_q.size(), 3);
        chk("lfsr_a0", exp_a_q[0], 32'h00000001);
        chk("lfsr_a1", exp_a_q[1], 32'h80200003);
        chk("lfsr_a2", exp_a_q[2], 32'hC0300002);
        chk("lfsr_b0", exp_b_q[0], 32'h0000ACE1);
        chk("lfsr_cnt", o_vec_cnt, 32'd3);
        chk("lfsr_busy", {31'b0, o_busy}, 32'h0);

        start_run(2'b01, 32'd4);
        wait_done(20);
        chk("sw_n", exp_a_q.size(), 4);
        chk("sw_a0", exp_a_q[0], 32'h0);
        chk("sw_b0", exp_b_q[0], 32'hFFFFFFFF);
        chk("sw_a3", exp_a_q[3], 32'h3);
        chk("sw_b3", exp_b_q[3], 32'hFFFFFFFC);

        start_run(2'b10, 32'd10);
        wait_done(30);
        chk("cn_n", exp_a_q.size(), 10);
        chk("cn_a3", exp_a_q[3], 32'hFFFFFFFF);
        chk("cn_b5", exp_b_q[5], 32'h80000000);
        chk("cn_a7", exp_a_q[7], 32'hAAAAAAAA);
        chk("cn_b7", exp_b_q[7], 32'h55555555);
        chk("cn_b8", exp_b_q[8], 32'h0);
        chk("cn_b9", exp_b_q[9], 32'h1);
        chk("cn_cnt", o_vec_cnt, 32'd10);

        start_run(2'b00, 32'd0);
        wait_vecs(5, 30);
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        chk("stop_n", exp_a_q.size(), 5);
        chk("stop_cnt", o_vec_cnt, 32'd5);
        chk("stop_done", {31'b0, o_done}, 32'h1);
        start_run(2'b00, 32'd2);
        wait_done(20);
        chk("replay_a0", exp_a_q[0], 32'h00000001);

        // start together with stop from DONE: start wins; mode 11 runs as LFSR
        i_stop = 1'b1;
        start_run(2'b11, 32'd2);
        i_stop = 1'b0;
        wait_done(20);
        chk("m3_a1", exp_a_q[1], 32'h80200003);

        // a second start during RUN is ignored
        start_run(2'b01, 32'd6);
        repeat (2) @(negedge clk);
        i_start = 1'b1; i_mode = 2'b10; i_num_vec = 32'd1;
        @(negedge clk);
        i_start = 1'b0;
        wait_done(30);
        chk("ign_n", exp_a_q.size(), 6);
        chk("ign_a5", exp_a_q[5], 32'h5);

        start_run(2'b01, 32'd0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("ar_ia", o_ia, 32'h0);
        chk("ar_ib", o_ib, 32'h0);
        chk("ar_valid", {31'b0, o_valid}, 32'h0);
        chk("ar_busy", {31'b0, o_busy}, 32'h0);
        chk("ar_done", {31'b0, o_done}, 32'h0);
        chk("ar_cnt", o_vec_cnt, 32'h0);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("ar_idle_busy", {31'b0, o_busy}, 32'h0);

`ifdef STIM_GEN_RESEED_EN
        i_seed_load = 1'b1; i_seed_a = 32'h0; i_seed_b = 32'h5;
        @(negedge clk);
        i_seed_load = 1'b0;
        start_run(2'b00, 32'd1);
        wait_done(20);
        chk("rs0_a0", exp_a_q[0], 32'h00000001);
        chk("rs0_b0", exp_b_q[0], 32'h00000005);

        i_seed_load = 1'b1; i_seed_a = 32'h2; i_seed_b = 32'h0;
        @(negedge clk);
        i_seed_load = 1'b0;
        start_run(2'b00, 32'd3);
        wait_done(20);
        chk("rs2_a0", exp_a_q[0], 32'h00000002);
        chk("rs2_a1", exp_a_q[1], 32'h00000001);
        chk("rs2_a2", exp_a_q[2], 32'h80200003);
        chk("rs2_b0", exp_b_q[0], 32'h00000001);

        start_run(2'b00, 32'd0);
        i_seed_load = 1'b1; i_seed_a = 32'h9; i_seed_b = 32'h9;
        @(negedge clk);
        i_seed_load = 1'b0;
        i_stop = 1'b1;
        @(negedge clk);
        i_stop = 1'b0;
        start_run(2'b00, 32'd1);
        wait_done(20);
        chk("rs_run_ign", exp_a_q[0], 32'h00000002);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
